viterbi_byte_framer: RTL
========================

Name: viterbi_byte_framer

Overview:
- Controller that sequences bit-to-byte assembly of decoded Viterbi output for one frame at a time.
- Takes serial decoded bits from the traceback unit with valid/ready flow control and packs them LSB-first into bytes.
- Counts payload bytes against a programmed frame length, strips the encoder tail bits, and buffers bytes in a small FIFO for the downstream byte sink.
- Sits between the decoder traceback output and the byte-level consumer (UART/host interface).

Parameters:
- TAIL_BITS, 6, encoder flush bits (K-1) discarded after the payload; 0 means no tail phase.
- FIFO_DEPTH, 4, output byte FIFO entries; a power of two, at least 2.
- LEN_W, 16, width of the frame length in bytes.

Ports:
- clk  in  1  clock; all logic is on the rising edge.
- rst  in  1  synchronous reset, active-high; one clock domain.
- start_i  in  1  1-cycle frame start request; honoured only in IDLE.
- abort_i  in  1  synchronous abort; highest priority after rst.
- frame_len_i  in  LEN_W  payload bytes in the frame; sampled when start is accepted.
- bit_i  in  1  decoded bit.
- bit_valid_i  in  1  bit_i is valid.
- bit_ready_o  out  1  framer accepts a bit this cycle; transfer happens when bit_valid_i && bit_ready_o.
- byte_o  out  8  FIFO head byte, first-word fall-through.
- byte_valid_o  out  1  FIFO is not empty.
- byte_ready_i  in  1  sink pops the head when byte_valid_o && byte_ready_i.
- busy_o  out  1  state != IDLE.
- frame_done_o  out  1  1-cycle pulse at frame completion.

Behaviour:
- Reset: state IDLE, FIFO empty, bit and byte counters 0, shift register 0. All outputs are 0 during and after reset, and byte_o reads 0.
- States are IDLE, PAYLOAD, TAIL and DRAIN.
- IDLE:
  - bit_ready_o = 0.
  - start_i latches frame_len_i into len_q.
  - Next state is PAYLOAD when len != 0, else TAIL when TAIL_BITS != 0, else DRAIN.
- PAYLOAD:
  - bit_ready_o = !fifo_full. fifo_full is the registered state, so a pop in the same cycle does not raise ready.
  - Each accepted bit is written to shreg[bit_cnt], then bit_cnt increments modulo 8.
  - On the 8th bit, the completed byte (including that bit) is pushed to the FIFO in the same edge. byte_valid_o can rise at the earliest on the next cycle.
  - byte_cnt increments on each push. On the push where byte_cnt+1 == len_q, go to TAIL, or to DRAIN if TAIL_BITS == 0.
- TAIL:
  - bit_ready_o = 1.
  - Accepted bits are discarded. After TAIL_BITS accepted bits, go to DRAIN.
- DRAIN:
  - bit_ready_o = 0.
  - When the FIFO is empty, assert frame_done_o for exactly 1 cycle and return to IDLE on the same edge.
- FIFO:
  - Push and pop in the same cycle is legal when the FIFO is neither empty nor full; occupancy is unchanged.
  - A push while full cannot occur, because ready is gated.
  - Pointers wrap modulo FIFO_DEPTH.
- Abort:
  - abort_i in any state: next cycle state IDLE, FIFO flushed (byte_valid_o = 0), counters cleared, no frame_done_o.
  - A partial byte is discarded.
  - abort_i together with start_i: abort wins and start is ignored.
- start_i outside IDLE is ignored; len_q is unchanged.
- Bits presented while bit_ready_o = 0 are not consumed. The source holds them.
- frame_len_i of max value (2^LEN_W - 1) must work; byte_cnt is LEN_W bits wide.

Decomposition:
- Package viterbi_pkg holds:
  - the state enum (FR_IDLE, FR_PAYLOAD, FR_TAIL, FR_DRAIN);
  - the constant VIT_TAIL_BITS = 6;
  - the byte width constant BYTE_W = 8.
- Sub-module sync_byte_fifo: DEPTH parameter, push/pop, full/empty, first-word fall-through head output.
- The framer FSM, shift register and counters live in viterbi_byte_framer.

Test Plan:
- Reset: hold rst = 1 for 2 cycles -> busy_o, byte_valid_o, bit_ready_o and frame_done_o are all 0; byte_o = 0x00.
- Single byte: start with len = 1, byte_ready_i = 1, send 0xA5 LSB-first then 6 tail bits -> byte_o = 0xA5 for one valid beat, frame_done_o pulses once after the FIFO empties, busy_o drops the same cycle.
- Backpressure:
  - Start with len = 6 and byte_ready_i = 0; send 0xFF, 0x00, 0x3C, 0x81, 0x5A, 0xC3.
  - Expect bit_ready_o = 0 once 4 bytes are queued.
  - Raise byte_ready_i -> all 6 bytes arrive in order with no loss or duplication, followed by tail bits and done.
- Zero length: start with len = 0 and send 6 tail bits -> no byte_valid_o and exactly one frame_done_o pulse.
- Abort: start with len = 3, abort after 12 bits (1 byte queued) -> next cycle byte_valid_o = 0, busy_o = 0, no done pulse. A following len = 1 frame with 0x5A outputs 0x5A only.
- Ignored start: pulse start_i with len = 9 mid-frame of a len = 2 frame -> the frame still ends after 2 bytes + 6 tail bits with a single done pulse.

Source files
------------

// File: rtl/viterbi_pkg.sv
// Shared types and constants for the Viterbi byte framer and its byte FIFO.
package viterbi_pkg;
  localparam int BYTE_W        = 8;
  localparam int VIT_TAIL_BITS = 6;

  typedef enum logic [1:0] {
    FR_IDLE    = 2'd0,
    FR_PAYLOAD = 2'd1,
    FR_TAIL    = 2'd2,
    FR_DRAIN   = 2'd3
  } fr_state_e;
endpackage

// File: rtl/viterbi_byte_framer_if.sv
// Bit-in / byte-out streaming bundle between traceback, framer and byte sink.
// Handshake: a transfer happens on a rising edge where valid and ready are both high;
// valid never waits on ready, and a producer holds its data stable until the transfer.
interface viterbi_byte_framer_if;
  import viterbi_pkg::*;

  logic              bit_i;
  logic              bit_valid_i;
  logic              bit_ready_o;
  logic [BYTE_W-1:0] byte_o;
  logic              byte_valid_o;
  logic              byte_ready_i;

  modport slave (
    input  bit_i, bit_valid_i, byte_ready_i,
    output bit_ready_o, byte_o, byte_valid_o
  );

  modport master (
    output bit_i, bit_valid_i, byte_ready_i,
    input  bit_ready_o, byte_o, byte_valid_o
  );
endinterface

// File: rtl/sync_byte_fifo.sv
// Single-clock byte FIFO with first-word fall-through head and synchronous flush.
module sync_byte_fifo
  import viterbi_pkg::*;
#(
  parameter int DEPTH = 4
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              flush,
  input  logic              push,
  input  logic [BYTE_W-1:0] push_data,
  input  logic              pop,
  output logic [BYTE_W-1:0] head,
  output logic              full,
  output logic              empty
);
  localparam int AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;

  logic [AW-1:0]     wr_ptr_q, wr_ptr_d;
  logic [AW-1:0]     rd_ptr_q, rd_ptr_d;
  logic [AW:0]       count_q, count_d;
  logic [BYTE_W-1:0] mem_q [DEPTH];
  logic              do_push, do_pop;

  assign full    = (count_q == (AW+1)'(DEPTH));
  assign empty   = (count_q == '0);
  assign do_push = push && !full;
  assign do_pop  = pop && !empty;
  // An empty FIFO presents zero rather than a stale entry.
  assign head    = empty ? '0 : mem_q[rd_ptr_q];

  always_comb begin
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    count_d  = count_q;
    if (flush) begin
      wr_ptr_d = '0;
      rd_ptr_d = '0;
      count_d  = '0;
    end else begin
      if (do_push) wr_ptr_d = wr_ptr_q + 1'b1;
      if (do_pop)  rd_ptr_d = rd_ptr_q + 1'b1;
      case ({do_push, do_pop})
        2'b10:   count_d = count_q + 1'b1;
        2'b01:   count_d = count_q - 1'b1;
        default: count_d = count_q;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
    end
  end

  always_ff @(posedge clk) begin
    if (do_push && !flush) mem_q[wr_ptr_q] <= push_data;
  end
endmodule

// File: rtl/viterbi_byte_framer.sv
// Packs decoded Viterbi bits LSB-first into bytes for one frame, drops the
// encoder tail bits, and queues payload bytes for the downstream sink.
module viterbi_byte_framer
  import viterbi_pkg::*;
#(
  parameter int TAIL_BITS  = VIT_TAIL_BITS,
  parameter int FIFO_DEPTH = 4,
  parameter int LEN_W      = 16
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  start_i,
  input  logic                  abort_i,
  input  logic [LEN_W-1:0]      frame_len_i,
  viterbi_byte_framer_if.slave  bus,
  output logic                  busy_o,
  output logic                  frame_done_o,
  output fr_state_e             state_o
);
  localparam int TCW = (TAIL_BITS > 1) ? $clog2(TAIL_BITS) : 1;

  fr_state_e         state_q, state_d;
  logic [LEN_W-1:0]  len_q, len_d;
  logic [LEN_W-1:0]  byte_cnt_q, byte_cnt_d;
  logic [2:0]        bit_cnt_q, bit_cnt_d;
  logic [BYTE_W-1:0] shreg_q, shreg_d;
  logic [TCW-1:0]    tail_cnt_q, tail_cnt_d;

  logic              fifo_full, fifo_empty;
  logic              fifo_push, fifo_flush;
  logic [BYTE_W-1:0] push_data;
  logic              bit_ready, bit_accept, done;

  // Ready comes from registered state only, so a same-cycle pop never raises it.
  assign bit_ready  = ((state_q == FR_PAYLOAD) && !fifo_full) || (state_q == FR_TAIL);
  assign bit_accept = bus.bit_valid_i && bit_ready;
  // The eighth bit goes straight into the pushed byte rather than through shreg.
  assign push_data  = {bus.bit_i, shreg_q[BYTE_W-2:0]};

  always_comb begin
    state_d    = state_q;
    len_d      = len_q;
    byte_cnt_d = byte_cnt_q;
    bit_cnt_d  = bit_cnt_q;
    shreg_d    = shreg_q;
    tail_cnt_d = tail_cnt_q;
    fifo_push  = 1'b0;
    fifo_flush = 1'b0;
    done       = 1'b0;

    case (state_q)
      FR_IDLE: begin
        if (start_i) begin
          len_d      = frame_len_i;
          byte_cnt_d = '0;
          bit_cnt_d  = '0;
          tail_cnt_d = '0;
          shreg_d    = '0;
          if (frame_len_i != '0)  state_d = FR_PAYLOAD;
          else if (TAIL_BITS != 0) state_d = FR_TAIL;
          else                     state_d = FR_DRAIN;
        end
      end
      FR_PAYLOAD: begin
        if (bit_accept) begin
          shreg_d[bit_cnt_q] = bus.bit_i;
          bit_cnt_d          = bit_cnt_q + 1'b1;
          if (bit_cnt_q == 3'd7) begin
            fifo_push  = 1'b1;
            byte_cnt_d = byte_cnt_q + 1'b1;
            if ((byte_cnt_q + 1'b1) == len_q) begin
              if (TAIL_BITS != 0) state_d = FR_TAIL;
              else                state_d = FR_DRAIN;
            end
          end
        end
      end
      FR_TAIL: begin
        if (bit_accept) begin
          if (tail_cnt_q == TCW'(TAIL_BITS - 1)) begin
            tail_cnt_d = '0;
            state_d    = FR_DRAIN;
          end else begin
            tail_cnt_d = tail_cnt_q + 1'b1;
          end
        end
      end
      FR_DRAIN: begin
        if (fifo_empty) begin
          done    = 1'b1;
          state_d = FR_IDLE;
        end
      end
      default: state_d = FR_IDLE;
    endcase

    // Abort overrides everything, including a start in the same cycle.
    if (abort_i) begin
      state_d    = FR_IDLE;
      byte_cnt_d = '0;
      bit_cnt_d  = '0;
      tail_cnt_d = '0;
      shreg_d    = '0;
      fifo_push  = 1'b0;
      fifo_flush = 1'b1;
      done       = 1'b0;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q    <= FR_IDLE;
      len_q      <= '0;
      byte_cnt_q <= '0;
      bit_cnt_q  <= '0;
      shreg_q    <= '0;
      tail_cnt_q <= '0;
    end else begin
      state_q    <= state_d;
      len_q      <= len_d;
      byte_cnt_q <= byte_cnt_d;
      bit_cnt_q  <= bit_cnt_d;
      shreg_q    <= shreg_d;
      tail_cnt_q <= tail_cnt_d;
    end
  end

  sync_byte_fifo #(.DEPTH(FIFO_DEPTH)) u_fifo (
    .clk       (clk),
    .rst       (rst),
    .flush     (fifo_flush),
    .push      (fifo_push),
    .push_data (push_data),
    .pop       (bus.byte_ready_i),
    .head      (bus.byte_o),
    .full      (fifo_full),
    .empty     (fifo_empty)
  );

  assign bus.bit_ready_o  = bit_ready;
  assign bus.byte_valid_o = !fifo_empty;
  assign busy_o           = (state_q != FR_IDLE);
  assign frame_done_o     = done;
  assign state_o          = state_q;
endmodule
